// File: rtl/nco_rate_meter.sv
// nco_rate_meter: measures a tick stream's rate as an NCO tuning word
//
// Counts single-cycle ticks over a gate window of 2^GATE_BITS clocks, then
// scales the count by a left shift of WORD_BITS-GATE_BITS. No division is
// needed. The result is the increment that makes a WORD_BITS-wide phase
// accumulator on the same clock reproduce the measured rate.
//
// Parameters
//   WORD_BITS   tuning word width (equals the target NCO accumulator width)
//   GATE_BITS   log2 of the gate window length, 1..WORD_BITS
//   CONTINUOUS  1 = back-to-back windows, 0 = single-shot on start
//
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active-low
//   tick_in      tick to measure; every high cycle is one tick
//   start        single-shot trigger (ignored when CONTINUOUS=1 or busy)
//   busy         high during the gate window
//   word_valid   one-cycle strobe when a new result is published
//   tuning_word  measured increment
//   saturated    last window had a tick on every cycle
//   no_tick      last window had no ticks
module nco_rate_meter #(
   parameter int WORD_BITS  = 20,
   parameter int GATE_BITS  = 20,
   parameter bit CONTINUOUS = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick_in,
   input  logic                 start,
   output logic                 busy,
   output logic                 word_valid,
   output logic [WORD_BITS-1:0] tuning_word,
   output logic                 saturated,
   output logic                 no_tick
);
   localparam int SH = WORD_BITS - GATE_BITS;
   typedef enum logic {IDLE, GATE} state_t;
   state_t               r_state;
   logic [GATE_BITS-1:0] r_win;
   logic [GATE_BITS:0]   r_cnt;
   logic [GATE_BITS:0]   w_n;
   logic                 w_last;
   logic [WORD_BITS-1:0] w_word;
   // w_n includes the current cycle's tick so the closing cycle is counted
   assign w_n    = r_cnt + {{GATE_BITS{1'b0}}, tick_in};
   assign w_last = (r_state == GATE) && (&r_win);
   // A full window (N = 2^GATE_BITS) would overflow the word; clamp to all-ones
   assign w_word = w_n[GATE_BITS] ? '1 : WORD_BITS'(w_n) << SH;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_win       <= '0;
         r_cnt       <= '0;
         busy        <= 1'b0;
         word_valid  <= 1'b0;
         tuning_word <= '0;
         saturated   <= 1'b0;
         no_tick     <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (r_state == IDLE) begin
            if (CONTINUOUS || start) begin
               r_state <= GATE;
               busy    <= 1'b1;
               r_win   <= '0;
               r_cnt   <= '0;
            end
         end else begin
            // r_win wraps to zero on the closing cycle, starting the next window
            r_win <= r_win + GATE_BITS'(1);
            r_cnt <= w_n;
            if (w_last) begin
               word_valid  <= 1'b1;
               tuning_word <= w_word;
               saturated   <= w_n[GATE_BITS];
               no_tick     <= (w_n == '0);
               r_cnt       <= '0;
               if (!CONTINUOUS) begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_nco_rate_meter.sv
// tb_nco_rate_meter: randomized bench for nco_rate_meter against a window-sum model
module tb_nco_rate_meter;
   logic        clk = 1'b0;
   logic [2:0]  rn, tk, st;
   logic [2:0]  bz, wv, sa, nt;
   logic [19:0] tw0, tw2;
   logic [11:0] tw1;
   int          total = 0, bad = 0;
   always #5 clk = ~clk;
   nco_rate_meter #(.WORD_BITS(20), .GATE_BITS(8), .CONTINUOUS(1'b1)) u0 (
      .clk(clk), .rst_n(rn[0]), .tick_in(tk[0]), .start(st[0]), .busy(bz[0]),
      .word_valid(wv[0]), .tuning_word(tw0), .saturated(sa[0]), .no_tick(nt[0]));
   nco_rate_meter #(.WORD_BITS(12), .GATE_BITS(12), .CONTINUOUS(1'b1)) u1 (
      .clk(clk), .rst_n(rn[1]), .tick_in(tk[1]), .start(st[1]), .busy(bz[1]),
      .word_valid(wv[1]), .tuning_word(tw1), .saturated(sa[1]), .no_tick(nt[1]));
   nco_rate_meter #(.WORD_BITS(20), .GATE_BITS(8), .CONTINUOUS(1'b0)) u2 (
      .clk(clk), .rst_n(rn[2]), .tick_in(tk[2]), .start(st[2]), .busy(bz[2]),
      .word_valid(wv[2]), .tuning_word(tw2), .saturated(sa[2]), .no_tick(nt[2]));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // reference: window membership by edge position, result from the tick sum
   int          gb[3] = '{8, 12, 8};
   int          wb[3] = '{20, 12, 20};
   bit          ct[3] = '{1'b1, 1'b1, 1'b0};
   bit          act[3] = '{default: 1'b0};
   int          pos[3] = '{default: 0};
   int          sum[3] = '{default: 0};
   int          pubs[3] = '{default: 0};
   logic        eb[3] = '{default: 1'b0};
   logic        ev[3] = '{default: 1'b0};
   logic        es[3] = '{default: 1'b0};
   logic        en[3] = '{default: 1'b0};
   logic [31:0] ew[3] = '{default: 32'd0};
   task automatic model_step(input int d, input bit r, input bit t, input bit s);
      int len;
      len = 1 << gb[d];
      if (!r) begin
         act[d] = 0; pos[d] = 0; sum[d] = 0;
         eb[d] = 0; ev[d] = 0; ew[d] = 0; es[d] = 0; en[d] = 0;
      end else begin
         ev[d] = 0;
         if (!act[d]) begin
            if (ct[d] || s) begin
               act[d] = 1; pos[d] = 0; sum[d] = 0; eb[d] = 1;
            end
         end else begin
            sum[d] += int'(t);
            pos[d]++;
            if (pos[d] == len) begin
               ev[d] = 1;
               pubs[d]++;
               ew[d] = (sum[d] == len) ? (1 << wb[d]) - 1 : sum[d] * (1 << (wb[d] - gb[d]));
               es[d] = (sum[d] == len);
               en[d] = (sum[d] == 0);
               pos[d] = 0;
               sum[d] = 0;
               if (!ct[d]) begin
                  act[d] = 0; eb[d] = 0;
               end
            end
         end
      end
   endtask
   function automatic logic [19:0] obs_tw(input int d);
      return d == 0 ? tw0 : d == 1 ? {8'h0, tw1} : tw2;
   endfunction
   initial begin
      logic [11:0] acc;
      logic        cy;
      bit          rdone, trk;
      int          c_r, last_v0, nv1, nv2, bc2, p;
      acc = 12'($urandom);
      rdone = 0; trk = 0; c_r = 0; last_v0 = 0; nv1 = 0; nv2 = 0; bc2 = 0;
      rn = '0; tk = '0; st = '0;
      for (int c = 0; c < 13000; c++) begin
         @(negedge clk);
         if (c > 0) begin
            for (int d = 0; d < 3; d++) begin
               chk($sformatf("busy%0d", d), 32'(bz[d]), 32'(eb[d]));
               chk($sformatf("valid%0d", d), 32'(wv[d]), 32'(ev[d]));
               chk($sformatf("word%0d", d), 32'(obs_tw(d)), ew[d]);
               chk($sformatf("sat%0d", d), 32'(sa[d]), 32'(es[d]));
               chk($sformatf("notick%0d", d), 32'(nt[d]), 32'(en[d]));
            end
            if (wv[0]) begin
               if (pubs[0] >= 1 && pubs[0] <= 3) chk("toggle0", 32'(tw0), 32'h80000);
               if (pubs[0] >= 2 && pubs[0] <= 3) chk("spacing0", c - last_v0, 256);
               if (pubs[0] == 4 || pubs[0] == 5) chk("sat0", {tw0, 11'h0, sa[0]}, {20'hFFFFF, 12'h1});
               if (pubs[0] == 6 || pubs[0] == 7) chk("zero0", {tw0, 11'h0, nt[0]}, {20'h0, 12'h1});
               if (pubs[0] == 11) chk("lasttick0", 32'(tw0), 32'h1000);
               if (pubs[0] == 12) chk("vcyc_cur0", 32'(tw0), 32'h0);
               if (pubs[0] == 13) chk("vcyc_next0", 32'(tw0), 32'h1000);
               if (trk) begin
                  chk("rstlat0", c - 1 - c_r, 257);
                  trk = 0;
               end
               last_v0 = c;
            end
            if (rdone && c == c_r + 1) chk("rstclr0", {tw0, 8'h0, bz[0], wv[0], sa[0], nt[0]}, 32'h0);
            if (wv[1]) begin
               chk("nco1", 32'(tw1), 32'h5A3);
               nv1++;
            end
            if (c < 300 && bz[2]) bc2++;
            if (c == 300) chk("busylen2", bc2, 256);
            if (wv[2] && c < 600) begin
               chk("lat2", c - 1 - 20, 256);
               chk("quarter2", 32'(tw2), 32'h40000);
               nv2++;
            end
            if (c == 600) chk("onepub2", nv2, 1);
         end
         rn = (c < 3) ? 3'b000 : 3'b111;
         p = pubs[0];
         tk[0] = p < 3  ? c[0] :
                 p < 5  ? 1'b1 :
                 p < 7  ? 1'b0 :
                 p == 10 ? (pos[0] == 255) :
                 p == 11 ? 1'b0 :
                 p == 12 ? ev[0] : 1'($urandom);
         if (p == 13 && !rdone && act[0] && pos[0] == 100) begin
            rn[0] = 1'b0;
            rdone = 1; trk = 1; c_r = c;
         end
         {cy, acc} = {1'b0, acc} + 13'h5A3;
         tk[1] = cy;
         st[2] = (c == 20) || (c == 150) || (c > 600 && $urandom_range(0, 63) == 0);
         tk[2] = c < 600 ? (c % 4 == 0) : 1'($urandom);
         st[0] = 1'($urandom);
         st[1] = 1'($urandom);
         for (int d = 0; d < 3; d++) model_step(d, rn[d], tk[d], st[d]);
      end
      chk("nco1_count", nv1, 3);
      chk("rst_seen0", {31'h0, rdone}, 32'h1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/nco_rate_meter.md
# nco_rate_meter

Measures the rate of a single-cycle enable/tick stream against the system clock. Returns the result as an NCO tuning word: the increment that, loaded into a WORD_BITS-wide phase-accumulator enable generator on the same clock, reproduces the measured rate. It sits on the receive side of the enable-generator path, for self-checking clock-enable chains and for calibrating increments from an observed reference tick. It uses no division: ticks are counted over a power-of-two gate window and then shifted.

## Interface

Parameters:
- WORD_BITS, 20, tuning word width; equals the NCO accumulator width.
- GATE_BITS, 20, gate window length is 2^GATE_BITS clocks; legal range 1..WORD_BITS.
- CONTINUOUS, 1, 1 = free-running back-to-back windows; 0 = single-shot on `start`.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous reset, active-low.
- tick_in  in  1  tick to measure, synchronous to clk; each high cycle counts as one tick.
- start  in  1  single-shot trigger; ignored when CONTINUOUS=1 or while busy.
- busy  out  1  high during the gate window.
- word_valid  out  1  one-cycle strobe; the new result is on the outputs.
- tuning_word  out  WORD_BITS  measured increment.
- saturated  out  1  the last window had a tick on every cycle.
- no_tick  out  1  the last window had zero ticks.

## Operation

- States: IDLE, GATE.
- Registers:
  - window counter, GATE_BITS wide.
  - tick counter, GATE_BITS+1 wide.
- Reset (rst_n low at a clk edge):
  - state goes to IDLE.
  - Both counters are cleared.
  - busy=0, word_valid=0, tuning_word=0, saturated=0, no_tick=0.
  - This applies in any state. A window in progress is discarded and nothing is published.
- IDLE:
  - CONTINUOUS=1: go to GATE on the first edge with rst_n high.
  - CONTINUOUS=0: go to GATE on an edge where start=1.
  - On entry to GATE, both counters are 0.
- GATE:
  - Each cycle, the window counter increments and the tick counter adds tick_in.
  - The last gate cycle is the one where the window counter is all-ones. Its tick_in is included.
- End of window (the edge that closes the last gate cycle). Let N = tick count plus tick_in.
  - If N = 2^GATE_BITS: tuning_word = all-ones, saturated=1.
  - Otherwise: tuning_word = N << (WORD_BITS−GATE_BITS), saturated=0.
  - no_tick = (N==0).
  - word_valid=1 for exactly one cycle.
  - CONTINUOUS=1: stay in GATE and clear both counters. The next window starts immediately, with no dead cycle, and the tick in the word_valid cycle belongs to the new window.
  - CONTINUOUS=0: go to IDLE.
- tuning_word, saturated and no_tick hold until the next publish or reset.
- start while busy=1 is ignored and does not restart the window.
- With GATE_BITS=WORD_BITS, a WORD_BITS-bit NCO with increment I produces exactly I carries in 2^WORD_BITS cycles. The result therefore equals I exactly, at any phase alignment.

## Timing

- Single-shot:
  - start sampled high at edge E: busy=1 from E through E+2^GATE_BITS.
  - At edge E+2^GATE_BITS: busy=0, word_valid=1 for one cycle.
  - start may be accepted again at the edge ending the word_valid cycle.
- Continuous: busy stays 1; word_valid pulses every 2^GATE_BITS cycles. The first pulse comes 2^GATE_BITS+1 cycles after reset release (one IDLE cycle, then the window).
- Latency from the last counted tick to the result is 0 cycles: the result is registered on the edge that closes the window.
- All outputs are registered.

## Test plan

- GATE_BITS=8, WORD_BITS=20, CONTINUOUS=1, tick_in toggling every cycle -> each word_valid gives tuning_word=0x80000 (128<<12), saturated=0, no_tick=0; pulses 256 cycles apart.
- Same config, tick_in held 1 -> tuning_word=0xFFFFF, saturated=1. Then tick_in held 0 -> next window tuning_word=0x00000, no_tick=1, saturated=0.
- GATE_BITS=20, WORD_BITS=20, tick_in driven by a 20-bit NCO with increment 0x5A3C7 at an arbitrary starting accumulator phase -> every tuning_word=0x5A3C7 exactly.
- GATE_BITS=8, CONTINUOUS=0: start pulse at edge E with one tick every 4 cycles -> busy=1 for exactly 256 cycles, word_valid at E+256, tuning_word=0x40000. A second start pulse mid-window has no effect (result time unchanged). After completion, busy=0 and outputs hold until the next start.
- Reset mid-window: rst_n low for 1 cycle at window cycle 100 -> all outputs 0 the following cycle, no word_valid. With CONTINUOUS=1 the next word_valid comes exactly 257 cycles after reset release, and its count covers only post-reset ticks.
- Boundary tick: tick only on the last gate cycle -> tuning_word=1<<12. Tick only in the word_valid cycle -> counted in the following window, not the current one.
